// File: rtl/crc5_unfold3_ctrl.sv
// Frame sequencer for a 3-bit-per-clock unfolded CRC-5 (1 + y + y^3 + y^5).
// Accepts a start/len command, folds one 3-bit chunk per handshake, reports remainder and compare.
module crc5_unfold3_ctrl #(
  parameter int unsigned LEN_W = 8,
  parameter logic [4:0]  POLY  = 5'b01011,
  parameter logic [4:0]  INIT  = 5'b00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [4:0]       exp_crc,
  input  logic             abort,
  input  logic [2:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [4:0]       crc_out,
  output logic             crc_ok,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned STEPS = 3;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic [4:0]       r_q;
  logic [LEN_W-1:0] rem_q;
  logic [4:0]       exp_q;
  logic [4:0]       crc_out_q;
  logic             crc_ok_q;
  logic             done_q;
  logic             err_q;

  logic             accept;
  logic             last;
  logic             frame_go;
  logic             frame_bad;
  logic [4:0]       r_next;

  // Serial steps chained combinationally; din[2] is the earliest bit, so it feeds stage 0.
  logic [4:0] r_chain [0:STEPS];
  assign r_chain[0] = r_q;

  for (genvar i = 0; i < STEPS; i++) begin : g_step
    crc5_step #(.POLY(POLY)) u_step (
      .r_in  (r_chain[i]),
      .b     (din[STEPS-1-i]),
      .r_out (r_chain[i+1])
    );
  end

  assign r_next = r_chain[STEPS];

  // Abort wins over acceptance, so a chunk offered alongside abort is dropped.
  assign accept    = (state_q == RUN) && din_valid && !abort;
  assign last      = accept && (rem_q == ONE);
  assign frame_go  = (state_q == IDLE) && start && (len != '0);
  assign frame_bad = (state_q == IDLE) && start && (len == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (frame_go) state_d = RUN;
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      r_q       <= INIT;
      rem_q     <= '0;
      exp_q     <= '0;
      crc_out_q <= '0;
      crc_ok_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= last;
      err_q   <= frame_bad;
      if (frame_go) begin
        rem_q <= len;
        exp_q <= exp_crc;
        r_q   <= INIT;
      end else if (accept) begin
        rem_q <= rem_q - ONE;
        r_q   <= r_next;
      end
      if (last) begin
        crc_out_q <= r_next;
        crc_ok_q  <= (r_next == exp_q);
      end
    end
  end

  assign din_ready = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign crc_out   = crc_out_q;
  assign crc_ok    = crc_ok_q;

endmodule

// One serial LFSR step of the CRC-5 remainder.
module crc5_step #(
  parameter logic [4:0] POLY = 5'b01011
) (
  input  logic [4:0] r_in,
  input  logic       b,
  output logic [4:0] r_out
);
  logic fb;
  assign fb    = b ^ r_in[4];
  assign r_out = {r_in[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);
endmodule

// File: tb/tb_crc5_unfold3_ctrl.sv
// Scoreboard bench for crc5_unfold3_ctrl: directed scenarios plus a random frame regression.
module tb_crc5_unfold3_ctrl;
  localparam int unsigned LEN_W = 8;
  localparam logic [4:0]  POLY  = 5'b01011;
  localparam logic [4:0]  INIT  = 5'b00000;

  logic             clk = 1'b0;
  logic             reset, start, abort, din_valid;
  logic [LEN_W-1:0] len;
  logic [4:0]       exp_crc;
  logic [2:0]       din;
  logic             din_ready, busy, done, crc_ok, err;
  logic [4:0]       crc_out;

  crc5_unfold3_ctrl #(.LEN_W(LEN_W), .POLY(POLY), .INIT(INIT)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .exp_crc(exp_crc),
    .abort(abort), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .busy(busy), .done(done), .crc_out(crc_out), .crc_ok(crc_ok), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] crc;
    logic       ok;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] msg[$];
  int         stall_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;
  int         err_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (err) err_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] model_crc();
    logic [4:0] r;
    logic       fb;
    r = INIT;
    foreach (msg[k]) begin
      for (int i = 2; i >= 0; i--) begin
        fb = msg[k][i] ^ r[4];
        r  = {r[3:0], 1'b0} ^ (fb ? POLY : 5'b00000);
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; abort = 1'b0; din_valid = 1'b0; din = 3'b000;
    len = '0; exp_crc = 5'b00000;
  endtask

  // Runs the frame held in msg/stall_q; expected exp_crc is the model, optionally flipped.
  task automatic run_frame(input logic flip, input string tag);
    logic [4:0] m;
    exp_t       e;
    int         d0;
    m = model_crc();
    e.crc = m;
    e.ok  = !flip;
    sb.push_back(e);
    d0 = done_cnt;
    start = 1'b1; len = LEN_W'(msg.size()); exp_crc = m ^ {4'b0000, flip};
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s start: busy=%b din_ready=%b want 1/1", tag, busy, din_ready);
    end
    foreach (msg[k]) begin
      for (int s = 0; s < stall_q[k]; s++) begin
        din_valid = 1'b0; din = $urandom_range(0, 7);
        step();
      end
      din_valid = 1'b1; din = msg[k];
      step();
      din_valid = 1'b0;
    end
    e = sb.pop_front();
    n_cmp++;
    if (done !== 1'b1 || crc_out !== e.crc || crc_ok !== e.ok) begin
      n_bad++;
      $display("FAIL %s result: done=%b crc_out=%b crc_ok=%b want 1 %b %b",
               tag, done, crc_out, crc_ok, e.crc, e.ok);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL %s after: done=%b busy=%b pulses=%0d want 0 0 1",
               tag, done, busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if ({din_ready, busy, done, err, crc_out, crc_ok} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset: rdy=%b busy=%b done=%b err=%b crc=%b ok=%b want all 0",
               din_ready, busy, done, err, crc_out, crc_ok);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    msg = {3'b101}; stall_q = {0};
    n_cmp++;
    if (model_crc() !== 5'b01100) begin
      n_bad++;
      $display("FAIL model single: got %b want 01100", model_crc());
    end
    run_frame(1'b0, "single");
  endtask

  task automatic test_stall();
    int b0;
    msg = {3'b000, 3'b001}; stall_q = {0, 3};
    b0 = busy_cnt;
    start = 1'b1; len = 8'd2; exp_crc = 5'b00000;
    sb.push_back('{crc: 5'b01011, ok: 1'b0});
    step();
    start = 1'b0;
    din_valid = 1'b1; din = 3'b000; step();
    din_valid = 1'b0; din = 3'b111; step(); step(); step();
    din_valid = 1'b1; din = 3'b001; step();
    din_valid = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (done !== 1'b1 || crc_out !== e.crc || crc_ok !== e.ok) begin
        n_bad++;
        $display("FAIL stall result: done=%b crc=%b ok=%b want 1 %b %b",
                 done, crc_out, crc_ok, e.crc, e.ok);
      end
    end
    step();
    n_cmp++;
    if (busy_cnt - b0 != 6) begin
      n_bad++;
      $display("FAIL stall busy: got %0d cycles want 6", busy_cnt - b0);
    end
  endtask

  task automatic test_zero_len();
    int b0;
    b0 = busy_cnt;
    start = 1'b1; len = '0; exp_crc = 5'b11111;
    step();
    start = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || crc_out !== 5'b01011) begin
      n_bad++;
      $display("FAIL zero_len: err=%b busy=%b done=%b crc=%b want 1 0 0 01011",
               err, busy, done, crc_out);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || busy_cnt != b0) begin
      n_bad++;
      $display("FAIL zero_len after: err=%b busy_cycles=%0d want 0 0", err, busy_cnt - b0);
    end
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    start = 1'b1; len = 8'd4; exp_crc = 5'b00000;
    step();
    start = 1'b0;
    din_valid = 1'b1; din = 3'b110; step();
    din = 3'b011; step();
    abort = 1'b1; din = 3'b111; step();
    abort = 1'b0; din_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || crc_out !== 5'b01011 || crc_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL abort: busy=%b done=%b crc=%b ok=%b want 0 0 01011 0",
               busy, done, crc_out, crc_ok);
    end
    step(); step();
    n_cmp++;
    if (done_cnt != d0) begin
      n_bad++;
      $display("FAIL abort pulses: got %0d want 0", done_cnt - d0);
    end
    msg = {3'b101}; stall_q = {0};
    run_frame(1'b0, "post_abort");
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start = 1'b1; len = 8'd3; exp_crc = 5'b00000;
    step();
    start = 1'b0;
    din_valid = 1'b1; din = 3'b101; step();
    din_valid = 1'b0;
    reset = 1'b1; start = 1'b1; len = 8'd1;
    step();
    reset = 1'b0; start = 1'b0;
    n_cmp++;
    if ({din_ready, busy, done, err, crc_out, crc_ok} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_mid: rdy=%b busy=%b done=%b err=%b crc=%b ok=%b want all 0",
               din_ready, busy, done, err, crc_out, crc_ok);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
      n_bad++;
      $display("FAIL reset_mid after: busy=%b pulses=%0d errs=%0d want 0 0 0",
               busy, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    msg = {3'b111, 3'b010, 3'b100}; stall_q = {0, 0, 0};
    run_frame(1'b0, "b2b_a");
    msg = {3'b001}; stall_q = {0};
    run_frame(1'b1, "b2b_b");
    msg = {3'b110, 3'b001}; stall_q = {0, 0};
    sb.push_back('{crc: model_crc(), ok: 1'b1});
    start = 1'b1; len = 8'd2; exp_crc = model_crc();
    step();
    start = 1'b0;
    din_valid = 1'b1; din = 3'b110; step();
    din = 3'b001; step();
    din_valid = 1'b0;
    begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (done !== 1'b1 || crc_out !== e.crc || crc_ok !== e.ok) begin
        n_bad++;
        $display("FAIL b2b_c result: done=%b crc=%b ok=%b want 1 %b %b",
                 done, crc_out, crc_ok, e.crc, e.ok);
      end
    end
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL start_in_done: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 1000; f++) begin
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 255) : $urandom_range(1, 40);
      msg.delete(); stall_q.delete();
      for (int k = 0; k < n; k++) begin
        msg.push_back(3'($urandom_range(0, 7)));
        stall_q.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0);
      end
      run_frame(1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_stall();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/crc5_unfold3_ctrl.md
# crc5_unfold3_ctrl

Frame controller and sequencer for the 3-bit-per-clock unfolded CRC-5 datapath (generator 1 + y + y³ + y⁵). It accepts a frame-start command with a chunk count, drives the 3-bit unfolded remainder update once per accepted chunk under a valid/ready handshake, and reports the final 5-bit remainder. It also reports a pass/fail compare against an expected CRC. It sits between the message source and the checker/transmitter that consumes the CRC.

## Interface
- LEN_W, 8, width of chunk-count field; frames are 1 .. 2^LEN_W−1 chunks of 3 bits.
- POLY, 5'b01011, low 5 coefficients of the generator (y³, y¹, y⁰).
- INIT, 5'b00000, remainder value loaded at frame start.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame-start request; sampled only in IDLE.
- len  in  LEN_W  number of 3-bit chunks in the frame; captured with start.
- exp_crc  in  5  expected remainder; captured with start.
- abort  in  1  terminates the current frame without completion.
- din  in  3  message chunk; din[2] is the earliest bit.
- din_valid  in  1  din holds a chunk.
- din_ready  out  1  controller accepts a chunk this cycle.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- crc_out  out  5  final remainder of the last completed frame.
- crc_ok  out  1  crc_out == captured exp_crc; valid from done onward.
- err  out  1  one-cycle pulse: start with len == 0.

## Operation
- The serial reference step for bit b is: fb = b ^ r[4]; r ← {r[3:0],1'b0} ^ (fb ? POLY : 0).
- One accepted chunk applies 3 serial steps in one cycle, in order din[2], din[1], din[0].
- The result equals M(y)·y⁵ mod G(y), with message bits MSB-first.
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN: on start && len≠0.
  - Capture len into remaining count, capture exp_crc, and load r ← INIT.
- IDLE, start && len==0: err = 1 for the next cycle; stay in IDLE.
- RUN: din_ready = 1.
  - Each cycle with din_valid: update r and decrement remaining.
  - Cycles without din_valid stall; r and remaining hold.
- RUN, acceptance of the chunk with remaining == 1 → DONE.
  - At that same edge, load crc_out ← updated r and crc_ok ← (updated r == exp_crc).
- DONE: done = 1 for exactly one cycle, din_ready = 0, then → IDLE.
- abort in RUN → IDLE at the next edge.
  - No done pulse; crc_out and crc_ok keep their previous values.
  - Any chunk presented in that cycle is not applied.
- abort has priority over chunk acceptance; abort in IDLE or DONE has no effect.
- start while busy is ignored and not queued.
- The controller does not look at din when din_ready = 0.

## Timing
- All outputs are registered, except din_ready and busy, which are decoded from state.
- Reset values: state IDLE, din_ready 0, busy 0, done 0, err 0, crc_out 5'b00000, crc_ok 0, r = INIT, remaining 0.
- start sampled at edge T → busy and din_ready are high in the cycle after T.
- Last chunk accepted at edge T → done = 1 and crc_out/crc_ok are valid in the cycle after T. done falls at T+1.
- Back-to-back frames: start may be sampled in the cycle after DONE, so the minimum frame period is len + 2 cycles.
- crc_out and crc_ok hold until the next completed frame or reset.
- reset mid-frame: the return to reset values happens at that edge; the partial frame is discarded, with no done and no err.
- err and done are never high in the same cycle.

## Test plan
- Single chunk: start, len=1, exp_crc=5'b01100, din=3'b101 → done one cycle later, crc_out=5'b01100, crc_ok=1.
- Two chunks with a stall: len=2, exp_crc=5'b00000; din 3'b000, then din_valid low 3 cycles, then 3'b001.
  - Expected: crc_out=5'b01011, crc_ok=0, done exactly once, busy high for 2+3+1 cycles.
- Zero length: start with len=0 → err pulse for one cycle, busy stays 0, crc_out unchanged.
- Abort: len=4, abort after 2 chunks → IDLE, no done, crc_out keeps the prior value (5'b01011).
  - A following frame (len=1, din=3'b101) yields 5'b01100.
- Reset mid-frame: synchronous reset after 1 of 3 chunks → all outputs at reset values next cycle.
  - start during the reset cycle is ignored.
- Random regression: 1000 frames of random len (1..255), random stalls, and exp_crc = model or model^1.
  - crc_out must match the serial bit model every frame, and crc_ok must match.
